prefix_adder_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor/incrementer for the floating-point divider datapath.
- Used for mantissa subtraction, exponent arithmetic and rounding increment.
- Generalises the fixed-width GP/prefix-combine/incrementer cells: any width, selectable latency, multiple modes, a valid/ready handshake and a tag carried alongside the data.

---
 rtl/adder_pkg.sv | 35 +++
 rtl/dff.sv | 32 +++
 rtl/prefix_cell.sv | 13 +
 rtl/prefix_adder_pipe.sv | 179 +++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and constant helpers for the pipelined parallel-prefix adder.
package adder_pkg;

  // Operation select carried on in_mode.
  typedef enum logic [1:0] {
    ADD_M = 2'd0,  // A + B
    SUB_M = 2'd1,  // A - B  (A + ~B + 1)
    INC_M = 2'd2,  // A + 1
    ADC_M = 2'd3   // A + B + cin
  } mode_t;

  // Generate/propagate pair handled by one prefix node.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Number of prefix levels completed before register rank k.
  function automatic int rank_level(input int k, input int lvl, input int pipe);
    return (k * lvl) / pipe;
  endfunction

endpackage

// File: rtl/dff.sv
// Enable flop with a synchronous-reset mux in front; building block for the
// pipeline ranks.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt_s;

  // Reset wins, then load on enable, otherwise hold.
  always_comb begin
    nxt_s = q;
    if (rst) begin
      nxt_s = {W{1'b0}};
    end else if (en) begin
      nxt_s = d;
    end else begin
      nxt_s = q;
    end
  end

  // Storage element.
  always_ff @(posedge clk) begin
    q <= nxt_s;
  end

endmodule

// File: rtl/prefix_cell.sv
// One Kogge-Stone combine node: (G,P) o (G',P') = (G | P&G', P&P').
module prefix_cell
  import adder_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t res
);

  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor/incrementer with valid/ready
// handshake and a tag that travels with each operation.
//
// The carry-in is folded into the tree as an extra position 0 with
// (g,p) = (c0,0), so extended position j stands for operand bit j-1 and the
// final G at position j is the carry into bit j.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int PIPE  = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LVL = clog2(WIDTH + 1);
  // Intermediate rank payload: G vector, P vector, bit propagates, tag, valid.
  localparam int RW  = 2 * (WIDTH + 1) + WIDTH + TAG_W + 1;
  // Output rank payload: sum, cout, ovf, zero, tag, valid.
  localparam int OW  = WIDTH + 3 + TAG_W + 1;

  logic             advance_s;
  logic             acc_s;
  logic [WIDTH-1:0] bp_s;
  logic             c0_s;

  // Per stage s: gg_s/pp_s[s][0] is the stage input, [s][l] after level l.
  logic [WIDTH:0]   gg_s  [PIPE][LVL+1];
  logic [WIDTH:0]   pp_s  [PIPE][LVL+1];
  logic [WIDTH-1:0] xp_s  [PIPE];
  logic [TAG_W-1:0] tag_s [PIPE];
  logic             vld_s [PIPE];

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;
  logic [OW-1:0]    out_d_s;
  logic [OW-1:0]    out_q_s;
  logic             unused_s;

  // One global enable: everything moves unless a result is stuck at the output.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s | rst;
  assign acc_s     = in_valid & in_ready;

  // Operand pre-conditioning selects B' and the carry-in for each mode.
  always_comb begin
    bp_s = in_b;
    c0_s = 1'b0;
    case (mode_t'(in_mode))
      ADD_M: begin
        bp_s = in_b;
        c0_s = 1'b0;
      end
      SUB_M: begin
        bp_s = ~in_b;
        c0_s = 1'b1;
      end
      INC_M: begin
        bp_s = {WIDTH{1'b0}};
        c0_s = 1'b1;
      end
      ADC_M: begin
        bp_s = in_b;
        c0_s = in_cin;
      end
      default: begin
        bp_s = in_b;
        c0_s = 1'b0;
      end
    endcase
  end

  // Bit cells, with the carry-in occupying extended position 0.
  assign gg_s[0][0] = {in_a & bp_s, c0_s};
  assign pp_s[0][0] = {in_a ^ bp_s, 1'b0};
  assign xp_s[0]    = in_a ^ bp_s;
  assign tag_s[0]   = in_tag;
  assign vld_s[0]   = acc_s;

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    // Stage s evaluates levels (LO, HI]; other levels are plain wires here.
    localparam int LO = rank_level(s, LVL, PIPE);
    localparam int HI = rank_level(s + 1, LVL, PIPE);

    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
      localparam int SPAN = 1 << (l - 1);

      if ((l > LO) && (l <= HI)) begin : g_comb
        for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
          if (j >= SPAN) begin : g_node
            gp_t hi_s;
            gp_t lo_s;
            gp_t res_s;

            assign hi_s.g = gg_s[s][l-1][j];
            assign hi_s.p = pp_s[s][l-1][j];
            assign lo_s.g = gg_s[s][l-1][j-SPAN];
            assign lo_s.p = pp_s[s][l-1][j-SPAN];

            prefix_cell u_cell (
              .hi  (hi_s),
              .lo  (lo_s),
              .res (res_s)
            );

            assign gg_s[s][l][j] = res_s.g;
            assign pp_s[s][l][j] = res_s.p;
          end else begin : g_pass
            // Already spans down to position 0; nothing left to combine.
            assign gg_s[s][l][j] = gg_s[s][l-1][j];
            assign pp_s[s][l][j] = pp_s[s][l-1][j];
          end
        end
      end else begin : g_skip
        assign gg_s[s][l] = gg_s[s][l-1];
        assign pp_s[s][l] = pp_s[s][l-1];
      end
    end

    if (s < PIPE - 1) begin : g_rank
      logic [RW-1:0] d_s;
      logic [RW-1:0] q_s;

      assign d_s = {gg_s[s][LVL], pp_s[s][LVL], xp_s[s], tag_s[s], vld_s[s]};

      dff #(.W(RW)) u_rank (
        .clk (clk),
        .rst (rst),
        .en  (advance_s),
        .d   (d_s),
        .q   (q_s)
      );

      assign {gg_s[s+1][0], pp_s[s+1][0], xp_s[s+1], tag_s[s+1], vld_s[s+1]} = q_s;
    end
  end

  // Sum and flags from the completed carry vector of the last stage.
  always_comb begin
    sum_s  = xp_s[PIPE-1] ^ gg_s[PIPE-1][LVL][WIDTH-1:0];
    cout_s = gg_s[PIPE-1][LVL][WIDTH];
    ovf_s  = gg_s[PIPE-1][LVL][WIDTH] ^ gg_s[PIPE-1][LVL][WIDTH-1];
    zero_s = ~|sum_s;
  end

  assign out_d_s = {sum_s, cout_s, ovf_s, zero_s, tag_s[PIPE-1], vld_s[PIPE-1]};

  dff #(.W(OW)) u_out (
    .clk (clk),
    .rst (rst),
    .en  (advance_s),
    .d   (out_d_s),
    .q   (out_q_s)
  );

  assign {out_sum, out_cout, out_ovf, out_zero, out_tag, out_valid} = out_q_s;

  // Group propagates of the final level have no consumer.
  assign unused_s = ^pp_s[PIPE-1][LVL];

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench: several configurations driven by one shared stimulus
// stream, each with its own arithmetic reference scoreboard.
module tb_prefix_adder_pipe;

  localparam int ND = 6;
  localparam int WD [ND] = '{8, 8, 24, 53, 8, 2};
  localparam int PD [ND] = '{2, 3, 1, 4, 4, 1};

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] m;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic [63:0] o_sum   [ND];
  logic        o_cout  [ND];
  logic        o_ovf   [ND];
  logic        o_zero  [ND];
  logic [3:0]  o_tag   [ND];
  logic        o_valid [ND];
  logic        i_ready [ND];

  exp_t        sbq [ND][$];
  logic        acc [ND];
  logic [3:0]  seen1[$];
  vec_t        dv [7];
  int          n_chk = 0;
  int          n_err = 0;
  int          sent;

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int W = WD[k];
    localparam int P = PD[k];
    logic [W-1:0] s_sum;
    logic         s_cout, s_ovf, s_zero, s_valid, s_ready;
    logic [3:0]   s_tag;

    prefix_adder_pipe #(.WIDTH(W), .PIPE(P), .TAG_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (s_ready),
      .in_a      (in_a[W-1:0]),
      .in_b      (in_b[W-1:0]),
      .in_cin    (in_cin),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (s_valid),
      .out_ready (out_ready),
      .out_sum   (s_sum),
      .out_cout  (s_cout),
      .out_ovf   (s_ovf),
      .out_zero  (s_zero),
      .out_tag   (s_tag)
    );

    assign o_sum[k]   = 64'(s_sum);
    assign o_cout[k]  = s_cout;
    assign o_ovf[k]   = s_ovf;
    assign o_zero[k]  = s_zero;
    assign o_tag[k]   = s_tag;
    assign o_valid[k] = s_valid;
    assign i_ready[k] = s_ready;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two's-complement value of a w-bit field.
  function automatic longint sval(input logic [63:0] v, input int w);
    longint x;
    x = longint'(v);
    if (v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference: plain modular arithmetic on A + B' + c0.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                 input logic [1:0] mode, input int w, input logic [3:0] tag);
    exp_t        e;
    logic [64:0] mask, av, bv, full;
    logic        c0;
    longint      ideal;
    mask = (65'd1 << w) - 65'd1;
    av   = {1'b0, a} & mask;
    case (mode)
      2'd0:    begin bv = {1'b0, b} & mask;  c0 = 1'b0; end
      2'd1:    begin bv = ~{1'b0, b} & mask; c0 = 1'b1; end
      2'd2:    begin bv = 65'd0;             c0 = 1'b1; end
      default: begin bv = {1'b0, b} & mask;  c0 = cin;  end
    endcase
    full   = av + bv + {64'd0, c0};
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.zero = (e.sum == 64'd0);
    ideal  = sval(av[63:0], w) + sval(bv[63:0], w) + longint'(c0);
    e.ovf  = (ideal != sval(e.sum, w));
    e.tag  = tag;
    return e;
  endfunction

  // Evaluate the transfers that the coming rising edge will perform.
  task automatic sb_step();
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      acc[k] = 1'b0;
      if (rst) begin
        sbq[k].delete();
      end else begin
        chk_eq($sformatf("d%0d.in_ready", k), 64'(i_ready[k]), 64'(!o_valid[k] || out_ready));
        if (o_valid[k] && out_ready) begin
          chk_eq($sformatf("d%0d.expected_pending", k), 64'(sbq[k].size() != 0), 64'd1);
          if (sbq[k].size() != 0) begin
            e = sbq[k].pop_front();
            chk_eq($sformatf("d%0d.sum", k),  o_sum[k],         e.sum);
            chk_eq($sformatf("d%0d.cout", k), 64'(o_cout[k]),   64'(e.cout));
            chk_eq($sformatf("d%0d.ovf", k),  64'(o_ovf[k]),    64'(e.ovf));
            chk_eq($sformatf("d%0d.zero", k), 64'(o_zero[k]),   64'(e.zero));
            chk_eq($sformatf("d%0d.tag", k),  64'(o_tag[k]),    64'(e.tag));
          end
          if (k == 1) seen1.push_back(o_tag[k]);
        end
        if (in_valid && i_ready[k]) begin
          sbq[k].push_back(model(in_a, in_b, in_cin, in_mode, WD[k], in_tag));
          acc[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    sb_step();
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk_eq($sformatf("%s.d%0d.valid", tag, k), 64'(o_valid[k]), 64'd0);
      chk_eq($sformatf("%s.d%0d.ready", tag, k), 64'(i_ready[k]), 64'd1);
      chk_eq($sformatf("%s.d%0d.sum", tag, k),   o_sum[k],        64'd0);
      chk_eq($sformatf("%s.d%0d.flags", tag, k), 64'({o_cout[k], o_ovf[k], o_zero[k]}), 64'd0);
      chk_eq($sformatf("%s.d%0d.tag", tag, k),   64'(o_tag[k]),   64'd0);
    end
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    dv[0] = '{8'h3C, 8'h05, 2'd0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
    dv[1] = '{8'h05, 8'h3C, 2'd1, 1'b0, 8'hC9, 1'b0, 1'b0, 1'b0};
    dv[2] = '{8'h3C, 8'h3C, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    dv[3] = '{8'h7F, 8'h01, 2'd0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    dv[4] = '{8'hFF, 8'hA5, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    dv[5] = '{8'hFE, 8'h01, 2'd3, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    dv[6] = '{8'h80, 8'h01, 2'd1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = 64'd0; in_b = 64'd0;
    in_cin = 1'b0; in_mode = 2'd0; in_tag = 4'd0; out_ready = 1'b1;
    step();
    chk_cleared("reset");
    step();
    rst = 1'b0;
    idle(1);

    // Directed vectors on the WIDTH=8, PIPE=2 instance with latency check.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a = {56'd0, dv[i].a}; in_b = {56'd0, dv[i].b};
      in_mode = dv[i].m; in_cin = dv[i].cin; in_tag = 4'(i + 1);
      step();
      in_valid = 1'b0;
      chk_eq($sformatf("dir%0d.early", i), 64'(o_valid[0]), 64'd0);
      step();
      chk_eq($sformatf("dir%0d.valid", i), 64'(o_valid[0]), 64'd1);
      chk_eq($sformatf("dir%0d.sum", i),   o_sum[0],        64'(dv[i].s));
      chk_eq($sformatf("dir%0d.cout", i),  64'(o_cout[0]),  64'(dv[i].co));
      chk_eq($sformatf("dir%0d.ovf", i),   64'(o_ovf[0]),   64'(dv[i].ov));
      chk_eq($sformatf("dir%0d.zero", i),  64'(o_zero[0]),  64'(dv[i].z));
      chk_eq($sformatf("dir%0d.tag", i),   64'(o_tag[0]),   64'(i + 1));
    end
    idle(6);

    // Backpressure: tags 0..7 back-to-back, consumer stalls cycles 5..8.
    seen1.delete();
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c <= 8);
      in_valid  = (sent < 8);
      in_tag    = 4'(sent);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      in_mode   = 2'($urandom_range(0, 3));
      in_cin    = 1'($urandom_range(0, 1));
      step();
      if (acc[1]) sent++;
    end
    chk_eq("bp.count", 64'(seen1.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen1.size()) chk_eq($sformatf("bp.order%0d", i), 64'(seen1[i]), 64'(i));
    end
    idle(6);

    // Mid-flight reset discards in-flight work.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      in_mode = 2'd0; in_tag = 4'(i + 9);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cleared("midrst");
    for (int n = 0; n < 4; n++) begin
      step();
      for (int k = 0; k < ND; k++) chk_eq($sformatf("midrst.d%0d.quiet", k), 64'(o_valid[k]), 64'd0);
    end
    in_valid = 1'b1; in_a = 64'h1; in_b = 64'h1; in_mode = 2'd0; in_tag = 4'd5;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int k = 0; k < ND; k++)
        chk_eq($sformatf("midrst.d%0d.lat%0d", k, n), 64'(o_valid[k]), 64'(n == PD[k]));
      step();
    end
    idle(6);

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) in_a = {64{1'b1}};
      if ($urandom_range(0, 15) == 0) in_b = in_a;
      in_cin    = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = 4'($urandom_range(0, 15));
      step();
    end
    idle(20);
    for (int k = 0; k < ND; k++) chk_eq($sformatf("d%0d.drained", k), 64'(sbq[k].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
